// File: rtl/encoder_4_to_2_seq_pkg.sv
// Shared definitions for the sequential 4:2 encoder.
//   LINES / CODE_W : request line count and encoded index width
//   state_t        : handshake FSM states
//   code_to_onehot : index -> one-hot line (same mapping as decoder_2_to_4)
package encoder_pkg;

    localparam int unsigned LINES  = 4;
    localparam int unsigned CODE_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    function automatic logic [LINES-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
        logic [LINES-1:0] oh;
        oh       = '0;
        oh[code] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/encoder_4_to_2_seq_if.sv
// Event/valid-ready bundle of the sequential 4:2 encoder.
//   req       : event pulses, one per cycle per line
//   out_ready : consumer accepts out_code
//   out_valid : out_code holds a valid index
//   out_code  : granted line index
//   out_multi : more than one line was pending when out_code was loaded
//   pending   : sticky pending events
//   overflow  : one-cycle pulse when an event is lost
// master = event source / code consumer, slave = the encoder.
interface encoder_4_to_2_seq_if import encoder_pkg::*; ();

    logic [LINES-1:0]  req;
    logic              out_ready;
    logic              out_valid;
    logic [CODE_W-1:0] out_code;
    logic              out_multi;
    logic [LINES-1:0]  pending;
    logic              overflow;

    modport master (
        output req, out_ready,
        input  out_valid, out_code, out_multi, pending, overflow
    );

    modport slave (
        input  req, out_ready,
        output out_valid, out_code, out_multi, pending, overflow
    );

endinterface

// File: rtl/encoder_4_to_2_seq_pick.sv
// Combinational line selector for the encoder.
//   vec   : candidate lines
//   ptr   : round-robin start line (ignored when RR = 0)
//   code  : selected line index (0 when vec is empty)
//   any   : vec has at least one line set
//   multi : vec has more than one line set
// RR = 0 picks the highest set line; RR = 1 picks the first set line
// scanning upward from ptr with wrap-around.
module encoder_pick import encoder_pkg::*; #(
    parameter bit RR = 1'b0
) (
    input  logic [LINES-1:0]  vec,
    input  logic [CODE_W-1:0] ptr,
    output logic [CODE_W-1:0] code,
    output logic              any,
    output logic              multi
);

    logic [CODE_W-1:0] idx;
    logic              found;

    always_comb begin
        code  = '0;
        idx   = '0;
        found = 1'b0;
        any   = |vec;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi = |(vec & (vec - LINES'(1)));

        if (RR) begin
            for (int unsigned i = 0; i < LINES; i++) begin
                idx = ptr + CODE_W'(i);
                if (!found && vec[idx]) begin
                    code  = idx;
                    found = 1'b1;
                end
            end
        end else begin
            // Ascending scan: the last hit is the highest set line.
            for (int unsigned i = 0; i < LINES; i++) begin
                if (vec[i]) begin
                    code = CODE_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/encoder_4_to_2_seq.sv
// Sequential 4:2 encoder.
// Captures event pulses on four request lines into a sticky pending register,
// grants one line per handshake (fixed priority or round-robin) and presents
// its 2-bit index on a valid/ready output.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : encoder_4_to_2_seq_if.slave (req, out_ready in; out_valid,
//         out_code, out_multi, pending, overflow out)
module encoder_4_to_2_seq import encoder_pkg::*; #(
    parameter bit RR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    encoder_4_to_2_seq_if.slave  bus
);

    state_t            state_q, state_d;
    logic [LINES-1:0]  pending_q;
    logic [CODE_W-1:0] code_q, code_d;
    logic              multi_q, multi_d;
    logic              overflow_q;
    logic [CODE_W-1:0] ptr_q;

    logic              accept;
    logic [LINES-1:0]  clr;
    logic [LINES-1:0]  rem;
    logic [LINES-1:0]  pick_vec;
    logic [CODE_W-1:0] pick_code;
    logic              pick_any;
    logic              pick_multi;

    assign accept = (state_q == VALID) && bus.out_ready;
    assign clr    = accept ? code_to_onehot(code_q) : '0;
    // rem equals pending when nothing is accepted, so it doubles as the
    // surviving-pending term of the register update and overflow detect.
    assign rem    = pending_q & ~clr;

    // One selector serves both the IDLE load (pending) and the reload on
    // acceptance (rem); new req bits are deliberately not considered.
    assign pick_vec = (state_q == VALID) ? rem : pending_q;

    encoder_pick #(
        .RR (RR)
    ) u_pick (
        .vec   (pick_vec),
        .ptr   (ptr_q),
        .code  (pick_code),
        .any   (pick_any),
        .multi (pick_multi)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        multi_d = multi_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = VALID;
                    code_d  = pick_code;
                    multi_d = pick_multi;
                end
            end
            VALID: begin
                if (accept) begin
                    if (pick_any) begin
                        code_d  = pick_code;
                        multi_d = pick_multi;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            code_q     <= '0;
            multi_q    <= 1'b0;
            overflow_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            multi_q    <= multi_d;
            // A request on a line being cleared this cycle re-sets it.
            pending_q  <= rem | bus.req;
            overflow_q <= |(bus.req & rem);
            if (accept) begin
                ptr_q <= code_q + CODE_W'(1);
            end
        end
    end

    assign bus.out_valid = (state_q == VALID);
    assign bus.out_code  = code_q;
    assign bus.out_multi = multi_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_encoder_4_to_2_seq.sv
// Scoreboard bench for encoder_4_to_2_seq: one fixed-priority and one
// round-robin instance share the same req/out_ready stimulus.
module tb_encoder_4_to_2_seq;
    import encoder_pkg::*;

    typedef struct packed {
        logic [1:0] code;
        logic       multi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    bit rand_phase = 1'b0;
    int credit [2][4];
    int grants [2];
    int ovfs   [2];
    int events;

    int fp_seq [9] = '{3, 2, 3, 1, 3, 2, 3, 1, 0};
    int rr_seq [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    encoder_4_to_2_seq_if bus_fp ();
    encoder_4_to_2_seq_if bus_rr ();

    assign bus_fp.req       = req;
    assign bus_fp.out_ready = out_ready;
    assign bus_rr.req       = req;
    assign bus_rr.out_ready = out_ready;

    encoder_4_to_2_seq #(.RR(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));
    encoder_4_to_2_seq #(.RR(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));

    logic       o_valid [2];
    logic [1:0] o_code  [2];
    logic       o_multi [2];
    logic [3:0] o_pend  [2];
    logic       o_ovf   [2];

    assign o_valid[0] = bus_fp.out_valid;
    assign o_code[0]  = bus_fp.out_code;
    assign o_multi[0] = bus_fp.out_multi;
    assign o_pend[0]  = bus_fp.pending;
    assign o_ovf[0]   = bus_fp.overflow;
    assign o_valid[1] = bus_rr.out_valid;
    assign o_code[1]  = bus_rr.out_code;
    assign o_multi[1] = bus_rr.out_multi;
    assign o_pend[1]  = bus_rr.pending;
    assign o_ovf[1]   = bus_rr.overflow;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endfunction

    // Monitors: pop expected codes on every handshake, or in the random phase
    // decode the code to a line and consume a recorded event on it.
    for (genvar g = 0; g < 2; g++) begin : mon
        exp_t       q[$];
        exp_t       e;
        logic       held = 1'b0;
        logic [1:0] held_code = '0;
        logic [3:0] oh;

        always @(negedge clk) begin
            if (rst) begin
                held <= 1'b0;
            end else begin
                if (held && o_valid[g])
                    chk($sformatf("hold_code[%0d]", g), o_code[g], held_code);
                if (o_valid[g] && out_ready) begin
                    if (rand_phase) begin
                        oh = code_to_onehot(o_code[g]);
                        for (int i = 0; i < 4; i++) begin
                            if (oh[i]) begin
                                chk($sformatf("line_has_event[%0d] line %0d", g, i),
                                    int'(credit[g][i] > 0), 1);
                                if (credit[g][i] > 0) credit[g][i]--;
                            end
                        end
                        grants[g]++;
                    end else if (q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_grant[%0d]: got code %0d, want no grant",
                                 g, o_code[g]);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("grant_code[%0d]", g), o_code[g], e.code);
                        chk($sformatf("grant_multi[%0d]", g), o_multi[g], e.multi);
                    end
                end
                if (rand_phase && o_ovf[g]) ovfs[g]++;
                held      <= o_valid[g] && !out_ready;
                held_code <= o_code[g];
            end
        end
    end

    task automatic push(input int g, input int code, input int multi);
        exp_t x;
        x.code  = 2'(code);
        x.multi = 1'(multi);
        if (g == 0) mon[0].q.push_back(x);
        else        mon[1].q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_valid[%0d]", tag, g), o_valid[g], 0);
            chk($sformatf("%s_code[%0d]", tag, g), o_code[g], 0);
            chk($sformatf("%s_multi[%0d]", tag, g), o_multi[g], 0);
            chk($sformatf("%s_pending[%0d]", tag, g), o_pend[g], 0);
            chk($sformatf("%s_overflow[%0d]", tag, g), o_ovf[g], 0);
        end
    endtask

    task automatic chk_both(input string name, input int which, input int exp);
        for (int g = 0; g < 2; g++) begin
            case (which)
                0: chk($sformatf("%s_valid[%0d]", name, g), o_valid[g], exp);
                1: chk($sformatf("%s_pending[%0d]", name, g), o_pend[g], exp);
                default: chk($sformatf("%s_overflow[%0d]", name, g), o_ovf[g], exp);
            endcase
        end
    endtask

    task automatic chk_queues(input string tag);
        chk($sformatf("%s_queue_empty[0]", tag), mon[0].q.size(), 0);
        chk($sformatf("%s_queue_empty[1]", tag), mon[1].q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single event on line 2.
        do_reset();
        chk_reset("reset");
        push(0, 2, 0);
        push(1, 2, 0);
        req = 4'b0100; out_ready = 1'b1;
        step();
        req = '0;
        chk_both("single_p1", 0, 0);
        chk_both("single_p1", 1, 4'b0100);
        step();
        chk_both("single_p2", 0, 1);
        step();
        chk_both("single_p3", 0, 0);
        chk_both("single_p3", 1, 0);
        chk_queues("single");

        // Back-pressure with 1011, then back-to-back drain.
        do_reset();
        push(0, 3, 1); push(0, 1, 1); push(0, 0, 0);
        push(1, 0, 1); push(1, 1, 1); push(1, 3, 0);
        req = 4'b1011; out_ready = 1'b0;
        step();
        req = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid_fp", o_valid[0], 1);
            chk("bp_code_fp", o_code[0], 3);
            chk("bp_multi_fp", o_multi[0], 1);
        end
        out_ready = 1'b1;
        step();
        chk_both("bp_drain1", 0, 1);
        step();
        chk_both("bp_drain2", 0, 1);
        step();
        chk_both("bp_drain3", 0, 0);
        chk_both("bp_drain3", 1, 0);
        chk_queues("bp");

        // All lines requested every other cycle.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            push(0, fp_seq[k], (k < 8) ? 1 : 0);
            push(1, rr_seq[k], (k < 8) ? 1 : 0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req = (k % 2 == 0 && k < 8) ? 4'b1111 : 4'b0000;
            step();
        end
        req = '0;
        step();
        step();
        chk_both("rr_end", 0, 0);
        chk_queues("rr");

        // Overflow, then a re-request in the acceptance cycle.
        do_reset();
        push(0, 2, 0); push(0, 2, 0);
        push(1, 2, 0); push(1, 2, 0);
        req = 4'b0100; out_ready = 1'b0;
        step();
        chk_both("ovf_p1", 2, 0);
        req = '0;
        step();
        chk_both("ovf_p2", 2, 0);
        chk_both("ovf_p2", 0, 1);
        req = 4'b0100;
        step();
        chk_both("ovf_p3", 2, 1);
        req = '0;
        step();
        chk_both("ovf_p4", 2, 0);
        chk_both("ovf_p4", 1, 4'b0100);
        req = 4'b0100; out_ready = 1'b1;
        step();
        chk_both("same_cycle", 2, 0);
        chk_both("same_cycle", 1, 4'b0100);
        chk_both("same_cycle", 0, 0);
        req = '0;
        step();
        chk_both("regrant", 0, 1);
        step();
        chk_both("regrant_done", 0, 0);
        chk_both("regrant_done", 1, 0);
        chk_queues("ovf");

        // Asynchronous reset while a grant is outstanding.
        do_reset();
        req = 4'b0110; out_ready = 1'b0;
        step();
        req = '0;
        step();
        chk_both("pre_rst", 0, 1);
        chk_both("pre_rst", 1, 4'b0110);
        chk("pre_rst_code_fp", o_code[0], 2);
        chk("pre_rst_code_rr", o_code[1], 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        step();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_both("post_rst", 0, 0);
            chk_both("post_rst", 1, 0);
        end
        chk_queues("rst");

        // Random events with decoder loopback accounting.
        do_reset();
        for (int g = 0; g < 2; g++) begin
            grants[g] = 0;
            ovfs[g]   = 0;
            for (int i = 0; i < 4; i++) credit[g][i] = 0;
        end
        events     = 0;
        rand_phase = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            int r;
            r = int'($urandom_range(0, 7));
            req = (r < 4) ? code_to_onehot(2'(r)) : 4'b0000;
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    events++;
                    credit[0][i]++;
                    credit[1][i]++;
                end
            end
            step();
        end
        req = '0;
        out_ready = 1'b1;
        begin
            int budget;
            budget = 0;
            while (budget < 20 && (o_valid[0] || o_valid[1] ||
                   o_pend[0] != 0 || o_pend[1] != 0)) begin
                step();
                budget++;
            end
            chk("drain_in_budget", int'(budget < 20), 1);
        end
        step();
        step();
        rand_phase = 1'b0;
        chk("events_vs_grants_fp", events, grants[0] + ovfs[0]);
        chk("events_vs_grants_rr", events, grants[1] + ovfs[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/encoder_4_to_2_seq.md
# encoder_4_to_2_seq

Sequential 4:2 encoder: the encode-side counterpart of the team's 2:4 decoder. It captures event pulses on four request lines into a sticky pending register, selects one line per handshake by fixed priority or round-robin, and emits its 2-bit index on a valid/ready output. A downstream `decoder_2_to_4` fed with `out_code` regenerates the one-hot line.

## Interface
- `RR`, default 0: arbitration policy.
  - 0: fixed priority, line 3 highest, line 0 lowest.
  - 1: round-robin.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 4: event lines. Each bit high for one cycle marks one event on that line.
- `out_ready` in 1: consumer accepts `out_code` when high while `out_valid` is high.
- `out_valid` out 1: `out_code` holds a valid index.
- `out_code` out 2: encoded index of the granted line. `req[3]` encodes to 2'b11; `req[0]` encodes to 2'b00.
- `out_multi` out 1: more than one pending bit was set when the current code was loaded.
- `pending` out 4: registered sticky pending events.
- `overflow` out 1: one-cycle pulse when an event is lost.

## Operation
Pending register update:
- Every cycle: `pending <= (pending & ~clr) | req`.
- `clr` is the one-hot of `out_code` when `out_valid & out_ready`; otherwise 0.
- If `req[i]` arrives in the same cycle that line i is cleared, the set wins and `pending[i]` stays 1. This is a new event, not an overflow.
- `overflow` pulses the next cycle when `req[i]=1`, `pending[i]=1`, and line i is not being cleared that cycle.

FSM states:
- IDLE: `out_valid=0`. If `pending != 0`, pick a line from the registered `pending`, load `out_code` and `out_multi`, then go to VALID.
- VALID: `out_valid=1`. `out_code` and `out_multi` are held stable until accepted.
- On acceptance in VALID, compute `rem = pending & ~clr`. New `req` bits are not included in `rem`.
  - If `rem != 0`: pick from `rem`, reload the outputs, and stay in VALID. This gives back-to-back grants.
  - If `rem == 0`: go to IDLE.

Selection:
- RR=0: highest-index set bit.
- RR=1: first set bit scanning upward from `ptr`, wrapping 3→0.
  - `ptr` is 2 bits and resets to 0.
  - On each acceptance, `ptr <= out_code + 1` (mod 4, so 3 wraps to 0).
- `out_multi = popcount(source vector) > 1`, where the source vector is `pending` (from IDLE) or `rem` (on reload).

## Timing
- Reset values (applied asynchronously): FSM=IDLE; `pending=0`; `out_valid=0`; `out_code=2'b00`; `out_multi=0`; `overflow=0`; `ptr=0`.
- Asserting `rst` mid-handshake drops `out_valid` immediately and discards all pending events.
- Latency:
  - `req` in cycle N sets `pending` at N+1.
  - From IDLE, `out_valid` rises at N+2.
- Throughput: one grant per cycle while `rem != 0`; otherwise one IDLE bubble.
- The consumer may hold `out_ready` high permanently. `out_code` must not change while `out_valid=1` and `out_ready=0`.

## Structure
- Shared package `encoder_pkg` holds:
  - FSM state enum (IDLE, VALID).
  - `LINES=4`, `CODE_W=2`.
  - One-hot-from-code function.
- One combinational sub-module, `encoder_pick`:
  - Inputs: vector, `ptr`, `RR`.
  - Outputs: `code`, `any`, `multi`.
  - Instantiated once with its input muxed between `pending` and `rem`.

## Test plan
- Single event: after reset, pulse `req=4'b0100` with `out_ready=1` → `out_valid` high 2 cycles later for exactly 1 cycle, `out_code=2'b10`, `out_multi=0`, `pending` returns to 0.
- Fixed priority, back-pressure: RR=0, `req=4'b1011`, `out_ready=0` for 5 cycles → `out_code=2'b11` held, `out_multi=1`. Then raise `out_ready` → codes 11, 01, 00 on consecutive cycles with no bubble, then IDLE.
- Round-robin: RR=1, `ptr=0`, `req=4'b1111` every other cycle, `out_ready=1` → grant sequence 00, 01, 10, 11, 00…
- Overflow and same-cycle re-request:
  - `req[2]` twice while `pending[2]=1` and not granted → `overflow` pulses once.
  - `req[2]` in the acceptance cycle of code 10 → no overflow, `pending[2]` stays 1, regrant later.
- Async reset mid-operation: `rst` pulsed while `out_valid=1` and `pending=4'b0110` → all outputs to reset values without waiting for a clock edge. No grant follows after reset release.
- Decoder loopback: drive `out_code` into `decoder_2_to_4` and randomise `req`/`out_ready` for 1000 cycles. Scoreboard checks:
  - Every accepted one-hot line matches a recorded event.
  - Event count equals grants plus overflows.
